// File: rtl/mem_port_sequencer.sv
// Two-requester round-robin front end for the 1024x12 word memory.
// Sequences address load, half commits and registered reads on a narrow port.
module mem_port_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              mem_read_write,
  output logic              mem_write_commit,
  output logic [ADDR_W-1:0] mem_addr_data,
  input  logic [DATA_W-1:0] mem_result
);

  localparam int HALF_W = DATA_W / 2;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_ADDR  = 3'd1;
  localparam logic [2:0] WR_LO    = 3'd2;
  localparam logic [2:0] WR_HI    = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_ISSUE = 3'd5;
  localparam logic [2:0] RD_CAPT  = 3'd6;

  logic [2:0]        state;
  logic              ptr_b;
  logic              cap_b;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] b_hold;

  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic              rsp_pulse;
  logic [DATA_W-1:0] rsp_data;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant_b = b_req_valid & (~a_req_valid | ptr_b);
    grant_a = a_req_valid & ~grant_b;
  end

  assign a_req_ready = ~rst & (state == IDLE) & grant_a;
  assign b_req_ready = ~rst & (state == IDLE) & grant_b;
  assign accept      = a_req_ready | b_req_ready;

  // Sequencer state, captured request and per-requester held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr_b     <= 1'b0;
      cap_b     <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      a_hold    <= '0;
      b_hold    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_b     <= grant_b;
            cap_write <= grant_b ? b_req_write : a_req_write;
            cap_addr  <= grant_b ? b_req_addr : a_req_addr;
            cap_wdata <= grant_b ? b_req_wdata : a_req_wdata;
            ptr_b     <= ~grant_b;
            if (grant_b ? b_req_write : a_req_write) state <= WR_ADDR;
            else state <= RD_ISSUE;
          end
        end
        WR_ADDR: state <= WR_LO;
        WR_LO:   state <= WR_HI;
        WR_HI:   state <= WR_ACK;
        WR_ACK: begin
          if (cap_b) b_hold <= '0;
          else a_hold <= '0;
          state <= IDLE;
        end
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          if (cap_b) b_hold <= mem_result;
          else a_hold <= mem_result;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port drive decoded from registered state only.
  always_comb begin
    mem_read_write   = 1'b0;
    mem_write_commit = 1'b0;
    mem_addr_data    = '0;
    if (!rst) begin
      case (state)
        WR_ADDR: mem_addr_data = cap_addr;
        WR_LO: begin
          mem_write_commit            = 1'b1;
          mem_addr_data[HALF_W-1:0]   = cap_wdata[HALF_W-1:0];
        end
        WR_HI: begin
          mem_write_commit            = 1'b1;
          mem_addr_data[HALF_W]       = 1'b1;
          mem_addr_data[HALF_W-1:0]   = cap_wdata[DATA_W-1:HALF_W];
        end
        RD_ISSUE: begin
          mem_read_write = 1'b1;
          mem_addr_data  = cap_addr;
        end
        default: mem_addr_data = '0;
      endcase
    end
  end

  // Response pulse to the captured requester; rdata holds between pulses.
  always_comb begin
    rsp_pulse = ~rst & ((state == WR_ACK) | (state == RD_CAPT));
    rsp_data  = (state == RD_CAPT) ? mem_result : '0;
    a_rsp_valid = rsp_pulse & ~cap_b;
    b_rsp_valid = rsp_pulse & cap_b;
    a_rsp_rdata = rst ? '0 : (a_rsp_valid ? rsp_data : a_hold);
    b_rsp_rdata = rst ? '0 : (b_rsp_valid ? rsp_data : b_hold);
  end

  logic unused;
  assign unused = cap_write;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Scoreboard bench for mem_port_sequencer with a behavioural memory
// and a word-level reference model of the two requesters' view.
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0;
  logic        a_req_ready;
  logic        a_req_write = 1'b0;
  logic [9:0]  a_req_addr = '0;
  logic [11:0] a_req_wdata = '0;
  logic        a_rsp_valid;
  logic [11:0] a_rsp_rdata;
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_write = 1'b0;
  logic [9:0]  b_req_addr = '0;
  logic [11:0] b_req_wdata = '0;
  logic        b_rsp_valid;
  logic [11:0] b_rsp_rdata;
  logic        mem_read_write;
  logic        mem_write_commit;
  logic [9:0]  mem_addr_data;
  logic [11:0] mem_result = '0;

  mem_port_sequencer #(.ADDR_W(10), .DATA_W(12)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_write(a_req_write), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
    .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_write(b_req_write), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
    .b_rsp_rdata(b_rsp_rdata),
    .mem_read_write(mem_read_write),
    .mem_write_commit(mem_write_commit),
    .mem_addr_data(mem_addr_data), .mem_result(mem_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [11:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          grants[$];
  logic [11:0] ref_mem [1024];
  logic [11:0] mem [1024];
  logic [9:0]  mem_addr_reg = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: address load when idle, half commit, registered read.
  always @(posedge clk) begin
    if (mem_read_write) begin
      mem_result <= mem[mem_addr_data];
    end else if (mem_write_commit) begin
      if (mem_addr_data[6]) mem[mem_addr_reg][11:6] <= mem_addr_data[5:0];
      else mem[mem_addr_reg][5:0] <= mem_addr_data[5:0];
    end else begin
      mem_addr_reg <= mem_addr_data;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic on_accept(input bit id, input bit wr,
                           input logic [9:0] addr, input logic [11:0] wd);
    exp_t e;
    e.id = id;
    grants.push_back(int'(id));
    if (wr) begin
      ref_mem[addr] = wd;
      e.rdata = '0;
      e.cyc = cyc + 4;
    end else begin
      e.rdata = ref_mem[addr];
      e.cyc = cyc + 2;
    end
    exp_q.push_back(e);
  endtask

  task automatic on_rsp(input bit id, input logic [11:0] rd);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected id %0d rdata %0h cyc %0d", id, rd, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.id != id || e.rdata != rd || e.cyc != cyc) begin
        errors++;
        $display("FAIL rsp got id %0d rdata %0h cyc %0d want id %0d rdata %0h cyc %0d",
                 id, rd, cyc, e.id, e.rdata, e.cyc);
      end
    end
  endtask

  // Monitor: accept tracking, response scoreboard and commit bus shape.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_req_ready && b_req_ready) begin
        checks++;
        errors++;
        $display("FAIL both_ready got 1 want 0");
      end
      if (a_rsp_valid && b_rsp_valid) begin
        checks++;
        errors++;
        $display("FAIL both_rsp got 1 want 0");
      end else if (a_rsp_valid) begin
        on_rsp(1'b0, a_rsp_rdata);
      end else if (b_rsp_valid) begin
        on_rsp(1'b1, b_rsp_rdata);
      end
      if (mem_write_commit) begin
        chk("commit_upper_bits", {29'd0, mem_addr_data[9:7]}, 0);
        chk("commit_rw", int'(mem_read_write), 0);
      end
      if (a_req_valid && a_req_ready)
        on_accept(1'b0, a_req_write, a_req_addr, a_req_wdata);
      if (b_req_valid && b_req_ready)
        on_accept(1'b1, b_req_write, b_req_addr, b_req_wdata);
    end
  end

  task automatic req(input bit id, input bit wr,
                     input logic [9:0] addr, input logic [11:0] wd);
    int n;
    bit got;
    if (id) begin
      b_req_write = wr; b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
    end else begin
      a_req_write = wr; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = id ? b_req_ready : a_req_ready;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout id %0d got 0 want ready", id);
    end
    @(posedge clk);
    #1;
    if (id) b_req_valid = 1'b0;
    else a_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_ready"}, int'(a_req_ready), 0);
    chk({tag, "_b_ready"}, int'(b_req_ready), 0);
    chk({tag, "_rsp"}, int'({a_rsp_valid, b_rsp_valid}), 0);
    chk({tag, "_rdata"}, int'({a_rsp_rdata, b_rsp_rdata}), 0);
    chk({tag, "_mem"}, int'({mem_read_write, mem_write_commit, mem_addr_data}), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    grants.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    req(1'b0, 1'b1, 10'h155, 12'hABC);
    @(negedge clk);
    chk("wr_addr", int'({mem_read_write, mem_write_commit, mem_addr_data}), 12'h155);
    @(negedge clk);
    chk("wr_lo", int'({mem_read_write, mem_write_commit, mem_addr_data}), 12'h43C);
    @(negedge clk);
    chk("wr_hi", int'({mem_read_write, mem_write_commit, mem_addr_data}), 12'h46A);
    wait_drain();

    req(1'b0, 1'b0, 10'h155, 12'h000);
    @(negedge clk);
    chk("rd_issue", int'({mem_read_write, mem_write_commit, mem_addr_data}), 12'h955);
    wait_drain();
    chk("a_rdata_hold", int'(a_rsp_rdata), 12'hABC);

    req(1'b0, 1'b1, 10'h3FF, 12'hFFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ref_mem[10'h3FF] = 12'h03F;
    repeat (6) @(posedge clk);
    #1;
    req(1'b0, 1'b0, 10'h3FF, 12'h000);
    wait_drain();

    req(1'b1, 1'b1, 10'h000, 12'h000);
    req(1'b1, 1'b1, 10'h3FF, 12'hFFF);
    req(1'b0, 1'b0, 10'h000, 12'h000);
    req(1'b1, 1'b0, 10'h3FF, 12'h000);
    wait_drain();

    do_reset();
    fork
      req(1'b1, 1'b0, 10'h155, 12'h000);
      begin
        @(negedge clk);
        chk("b_first_ready", int'(b_req_ready), 1);
      end
    join
    wait_drain();
    grants.delete();
    fork
      req(1'b0, 1'b0, 10'h002, 12'h000);
      req(1'b1, 1'b0, 10'h003, 12'h000);
    join
    wait_drain();
    chk("ptr_after_b", grants.size() > 0 ? grants[0] : -1, 0);

    do_reset();
    fork
      for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 10'h001, 12'h123);
      for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 10'h001, 12'h000);
    join
    wait_drain();
    chk("rr_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), grants[i], i % 2);

    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        req(1'b0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                         : 10'($urandom_range(0, 7)),
            12'($urandom_range(0, 4095)));
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        req(1'b1, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                         : 10'($urandom_range(0, 7)),
            12'($urandom_range(0, 4095)));
      end
    join
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
